// File: rtl/wb_pkg.sv
// wb_pkg: shared types and load width codes for the register-file writeback unit
package wb_pkg;
  typedef enum logic [1:0] {ALU, MEM, PC4, IMM} wb_sel_e;
  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE, ERR} wb_state_e;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
endpackage

// File: rtl/load_align.sv
// load_align: picks the byte/half/word out of a memory word, extends it, flags illegal width/alignment
//   i_funct3 : load width code
//   i_offset : byte address [1:0]
//   i_rdata  : aligned 32-bit memory word
//   o_data   : extracted and extended value
//   o_illegal: reserved funct3 or misaligned access
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_offset,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data,
  output logic            o_illegal
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
  always_comb begin
    o_illegal = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111)
              || (((i_funct3 == LH) || (i_funct3 == LHU)) && i_offset[0])
              || ((i_funct3 == LW) && (i_offset != 2'b00));
    o_data = (i_funct3 == LB)  ? {{(XLEN-8){w_byte[7]}}, w_byte}
           : (i_funct3 == LBU) ? {{(XLEN-8){1'b0}}, w_byte}
           : (i_funct3 == LH)  ? {{(XLEN-16){w_half[15]}}, w_half}
           : (i_funct3 == LHU) ? {{(XLEN-16){1'b0}}, w_half}
           : i_rdata;
  end
endmodule

// File: rtl/regfile_writeback_unit.sv
// regfile_writeback_unit: selects the writeback source, waits for load data, and drives one register-file write
//   clk, rst_n (sync, active-low)
//   req_valid/req_ready handshake with req_rd, req_sel, req_alu, req_pc4, req_imm, req_funct3, req_offset
//   mem_rvalid/mem_rdata : load data return
//   rf_we/rf_wr/rf_wd    : register-file write port
//   wb_done/wb_err       : one-cycle retire / abort pulses
//   instret              : retired count, live only when WB_INSTRET_EN is defined (otherwise 0)
module regfile_writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [1:0]        req_sel,
  input  logic [XLEN-1:0]   req_alu,
  input  logic [XLEN-1:0]   req_pc4,
  input  logic [XLEN-1:0]   req_imm,
  input  logic [2:0]        req_funct3,
  input  logic [1:0]        req_offset,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wr,
  output logic [XLEN-1:0]   rf_wd,
  output logic              wb_done,
  output logic              wb_err,
  output logic [63:0]       instret
);
  localparam int CW = $clog2(MEM_TIMEOUT);
  wb_state_e       r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_funct3;
  logic [1:0]      r_offset;
  logic            w_acc, w_illegal;
  logic [2:0]      w_f3;
  logic [1:0]      w_off;
  logic [XLEN-1:0] w_ld_data;
  // One aligner serves both the legality check at accept (live request) and extraction in WAIT_MEM (latched fields)
  assign w_f3  = (r_state == IDLE) ? req_funct3 : r_funct3;
  assign w_off = (r_state == IDLE) ? req_offset : r_offset;
  load_align #(.XLEN(XLEN)) u_align (
    .i_funct3 (w_f3),
    .i_offset (w_off),
    .i_rdata  (mem_rdata),
    .o_data   (w_ld_data),
    .o_illegal(w_illegal)
  );
  assign req_ready = (r_state == IDLE);
  assign w_acc     = req_valid && req_ready;
  assign rf_we     = (r_state == WRITE) && (rf_wr != '0);
  assign wb_done   = (r_state == WRITE);
  assign wb_err    = (r_state == ERR);
  always_comb begin
    w_next = (r_state == IDLE) ? (!w_acc ? IDLE : (req_sel != MEM) ? WRITE : w_illegal ? ERR : WAIT_MEM)
           : (r_state == WAIT_MEM) ? (mem_rvalid ? WRITE : (r_cnt == CW'(MEM_TIMEOUT - 1)) ? ERR : WAIT_MEM)
           : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_offset <= '0;
      rf_wr    <= '0;
      rf_wd    <= '0;
    end else begin
      if (w_acc) begin
        r_funct3 <= req_funct3;
        r_offset <= req_offset;
        rf_wr    <= req_rd;
        r_cnt    <= '0;
        rf_wd    <= (req_sel == PC4) ? req_pc4 : (req_sel == IMM) ? req_imm : req_alu;
      end
      if (r_state == WAIT_MEM) begin
        r_cnt <= r_cnt + 1'b1;
        if (mem_rvalid) rf_wd <= w_ld_data;
      end
      r_state <= w_next;
    end
  end
`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;
  always_ff @(posedge clk) begin
    if (!rst_n) r_instret <= '0;
    else if (wb_done) r_instret <= r_instret + 64'd1;
  end
  assign instret = r_instret;
`else
  assign instret = '0;
`endif
endmodule
